id_arb_ctrl: RTL and testbench

ID_ARB_CTRL -- requirements
Module: id_arb_ctrl

---
 rtl/id_arb_ctrl.sv | 156 +++++++++++++++
 tb/tb_id_arb_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_arb_ctrl.sv
// Two-requester arbiter sharing one identifier recognizer, one whole string per grant.
// Optional stall timeout enabled by defining ID_ARB_TIMEOUT_EN (uses TIMEOUT_CYC).
module id_arb_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_src,
    output logic       res_match,
    output logic [7:0] res_len,
    output logic       res_abort
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    typedef enum logic [1:0] {S0, S1, S2} rec_t;

    state_t     state_q;
    rec_t       rec_q, rec_d;
    logic [7:0] len_q, len_d;
    logic       owner_q, last_q;
    logic       rdy0_q, rdy1_q;
    logic       res_valid_q, res_src_q, res_match_q;
    logic [7:0] res_len_q;

    logic       own_valid, own_ready, accept;
    logic [7:0] own_char;

    function automatic rec_t rec_next(input rec_t s, input logic [7:0] c);
        logic is_letter, is_digit;
        is_letter = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
        is_digit  = (c >= 8'h30 && c <= 8'h39);
        if (is_letter)              return S1;
        else if (is_digit && s != S0) return S2;
        else                        return S0;
    endfunction

    always_comb begin
        own_valid = owner_q ? req1_valid : req0_valid;
        own_char  = owner_q ? req1_char  : req0_char;
        own_ready = owner_q ? rdy1_q     : rdy0_q;
        accept    = (state_q == RUN) && own_valid && own_ready;
        rec_d     = rec_next(rec_q, own_char);
        len_d     = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
    end

`ifdef ID_ARB_TIMEOUT_EN
    localparam logic [15:0] STALL_LIM = 16'(TIMEOUT_CYC - 1);
    logic [15:0] stall_q;
    logic        res_abort_q;
    assign res_abort = res_abort_q;
`else
    assign res_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rec_q       <= S0;
            len_q       <= 8'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            rdy0_q      <= 1'b0;
            rdy1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_src_q   <= 1'b0;
            res_match_q <= 1'b0;
            res_len_q   <= 8'd0;
`ifdef ID_ARB_TIMEOUT_EN
            stall_q     <= 16'd0;
            res_abort_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rec_q <= S0;
                    len_q <= 8'd0;
`ifdef ID_ARB_TIMEOUT_EN
                    stall_q <= 16'd0;
`endif
                    // On a tie, the requester not served last wins.
                    if (req0_valid && (!req1_valid || last_q)) begin
                        owner_q <= 1'b0;
                        rdy0_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (req1_valid) begin
                        owner_q <= 1'b1;
                        rdy1_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
`ifdef ID_ARB_TIMEOUT_EN
                        stall_q <= 16'd0;
`endif
                        if (own_char == 8'h00) begin
                            state_q     <= REPORT;
                            rdy0_q      <= 1'b0;
                            rdy1_q      <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_src_q   <= owner_q;
                            res_match_q <= (rec_q == S2);
                            res_len_q   <= len_q;
`ifdef ID_ARB_TIMEOUT_EN
                            res_abort_q <= 1'b0;
`endif
                        end else begin
                            rec_q <= rec_d;
                            len_q <= len_d;
                        end
                    end
`ifdef ID_ARB_TIMEOUT_EN
                    else if (!own_valid) begin
                        if (stall_q == STALL_LIM) begin
                            state_q     <= REPORT;
                            rdy0_q      <= 1'b0;
                            rdy1_q      <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_src_q   <= owner_q;
                            res_match_q <= 1'b0;
                            res_len_q   <= len_q;
                            res_abort_q <= 1'b1;
                        end else begin
                            stall_q <= stall_q + 16'd1;
                        end
                    end
`endif
                end
                REPORT: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        last_q      <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = rdy0_q;
    assign req1_ready = rdy1_q;
    assign res_valid  = res_valid_q;
    assign res_src    = res_src_q;
    assign res_match  = res_match_q;
    assign res_len    = res_len_q;

endmodule

// File: tb/tb_id_arb_ctrl.sv
// Scoreboard bench for id_arb_ctrl: directed strings, expected results queued up front,
// a negedge monitor pops and compares every result handshake.
module tb_id_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready = 1'b1;
    logic       res_src, res_match, res_abort;
    logic [7:0] res_len;

    typedef struct packed {
        logic       src;
        logic       match;
        logic [7:0] len;
        logic       abort;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    id_arb_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_src(res_src), .res_match(res_match), .res_len(res_len), .res_abort(res_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", expq.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: result comparison, stability while stalled, ready exclusivity.
    exp_t held;
    bit   held_v = 0;
    bit   after_hs = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready && req1_ready) chk("ready_exclusive", 32'd1, 32'd0);
            if (res_valid) begin
                if (req0_ready || req1_ready) chk("ready_low_in_report", {req0_ready, req1_ready}, 32'd0);
                if (held_v)
                    chk("res_stable", {res_src, res_match, res_len, res_abort}, held);
                if (res_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_result", {res_src, res_match, res_len, res_abort}, 32'd0);
                        chk("unexpected_result_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("res_src", res_src, e.src);
                        chk("res_match", res_match, e.match);
                        chk("res_len", res_len, e.len);
                        chk("res_abort", res_abort, e.abort);
                    end
                    held_v   = 0;
                    after_hs = 1;
                end else begin
                    held   = {res_src, res_match, res_len, res_abort};
                    held_v = 1;
                end
            end else begin
                held_v = 0;
                if (after_hs) begin
                    chk("idle_after_handshake", res_valid, 1'b0);
                    after_hs = 0;
                end
            end
        end else begin
            held_v   = 0;
            after_hs = 0;
        end
    end

    task automatic set_req(input int id, input logic v, input logic [7:0] c);
        if (id == 0) begin req0_valid = v; req0_char = c; end
        else         begin req1_valid = v; req1_char = c; end
    endtask

    task automatic send_char(input int id, input logic [7:0] c);
        bit got;
        got = 0;
        set_req(id, 1'b1, c);
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) got = 1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input int id, input string s, input bit term);
        for (int i = 0; i < s.len(); i++) send_char(id, s[i]);
        if (term) begin
            send_char(id, 8'h00);
            chk("latency_res_valid", res_valid, 1'b1);
            chk("latency_res_src", res_src, id[0]);
        end
        set_req(id, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && (expq.size() != 0 || res_valid); k++) @(negedge clk);
        chk("drain_queue_empty", expq.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {req0_ready, req1_ready, res_valid, res_src, res_match, res_abort, res_len}, 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie straight after reset: req0 first, then strict alternation.
        expq.push_back('{1'b0, 1'b1, 8'd3, 1'b0});   // "ab1"
        expq.push_back('{1'b1, 1'b0, 8'd2, 1'b0});   // "xy"
        expq.push_back('{1'b0, 1'b1, 8'd2, 1'b0});   // "c9"
        expq.push_back('{1'b1, 1'b1, 8'd2, 1'b0});   // "d5"
        fork
            begin send_str(0, "ab1", 1); send_str(0, "c9", 1); end
            begin send_str(1, "xy", 1);  send_str(1, "d5", 1); end
        join
        drain();

        expq.push_back('{1'b0, 1'b1, 8'd4, 1'b0});
        send_str(0, "ab12", 1);
        drain();

        expq.push_back('{1'b1, 1'b0, 8'd3, 1'b0});
        send_str(1, "a1b", 1);
        expq.push_back('{1'b1, 1'b0, 8'd2, 1'b0});
        send_str(1, "9x", 1);
        drain();

        expq.push_back('{1'b0, 1'b0, 8'd0, 1'b0});   // empty string
        send_str(0, "", 1);
        drain();

        // Consumer stalls five cycles in REPORT.
        res_ready = 1'b0;
        expq.push_back('{1'b0, 1'b1, 8'd2, 1'b0});
        send_str(0, "a1", 1);
        repeat (5) @(negedge clk);
        chk("stall_res_valid_held", res_valid, 1'b1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain();

        // 300 letters then "7": length saturates at 255.
        expq.push_back('{1'b0, 1'b1, 8'd255, 1'b0});
        for (int i = 0; i < 300; i++) send_char(0, 8'h61 + 8'(i % 26));
        send_str(0, "7", 1);
        drain();

        // Owner stalls mid-string.
        send_str(0, "ab", 0);
`ifdef ID_ARB_TIMEOUT_EN
        expq.push_back('{1'b0, 1'b0, 8'd2, 1'b1});
        drain();
        send_str(0, "cd", 0);
`else
        repeat (30) @(negedge clk);
        chk("no_result_without_timeout", res_valid, 1'b0);
        chk("still_owned_ready", req0_ready, 1'b1);
`endif

        // Asynchronous reset mid-string discards it.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;

        expq.push_back('{1'b1, 1'b1, 8'd2, 1'b0});
        send_str(1, "q5", 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
